// File: rtl/skeleton_top.sv
// Whack-a-mole skeleton: small load/store processor with imem ROM, dmem RAM and
// regfile, plus memory-mapped PWM LEDs, capacitive touch pads and an LFSR RNG.
// Latency: loads take two cycles (synchronous dmem/MMIO read); other instructions take one. No backpressure.
// Ports: clock/reset (sync, active-high); imem/dmem/regfile buses exposed as outputs;
//        led_pins (18 PWM LEDs); capacitive_sensors_in (9 pads) / capacitive_sensors_out (charge drive).
module skeleton_top #(
    parameter int unsigned SENSE_THRESH = 20,
    parameter logic [63:0] RNG_SEED     = 64'h1F2E3D4C5B6A7988
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] address_imem,
    output logic [31:0] q_imem,
    output logic [11:0] address_dmem,
    output logic [31:0] d_dmem,
    output logic        wren_dmem,
    output logic [31:0] q_dmem,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic [31:0] data_writeReg,
    output logic [31:0] data_readRegA,
    output logic [31:0] data_readRegB,
    output logic [17:0] led_pins,
    input  logic [8:0]  capacitive_sensors_in,
    output logic        capacitive_sensors_out
);

    typedef enum logic {S_EXEC, S_LOAD} state_t;
    typedef enum logic [2:0] {RG_RAM, RG_LED, RG_TOUCH, RG_RAND, RG_NONE} region_t;

    localparam logic [4:0] OP_R = 5'd0, OP_J = 5'd1, OP_ADDI = 5'd5, OP_SW = 5'd7, OP_LW = 5'd8;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic [31:0]   register_output [32];
    logic [31:0]   dmem_mem [4096];
    logic [143:0]  led_commands;
    logic [7:0]    pwm, phase;
    logic [6:0]    delay_cnt [9];
    logic [8:0]    touch;
    logic [7:0]    cell_data [8];
    logic [7:0]    random_data;
    logic [63:0]   seeds;
    region_t       region, rd_region_q;
    logic [4:0]    led_idx_q;
    logic [31:0]   load_data, imm_sx;
    logic [4:0]    opcode, rd, rs, rt, aluop;
    logic          store_go, led_we;

    assign seeds = RNG_SEED;

    // ---------------- imem: reference program (combinational ROM) ----------------
    // Format: {op,rd,rs,imm17} / R: {0,rd,rs,rt,shamt,aluop,2'b0} / J: {1,target27}
    assign address_imem = pc[11:0];
    always_comb begin
        q_imem = 32'd0;
        case (address_imem)
            12'd0:   q_imem = {OP_ADDI, 5'd2,  5'd0, 17'd12345};
            12'd1:   q_imem = {OP_SW,   5'd2,  5'd0, 17'd0};
            12'd2:   q_imem = {OP_LW,   5'd20, 5'd0, 17'd0};
            12'd3:   q_imem = {OP_ADDI, 5'd21, 5'd0, 17'd1900};
            12'd4:   q_imem = {OP_ADDI, 5'd27, 5'd0, 17'd99};
            12'd5:   q_imem = {OP_ADDI, 5'd1,  5'd0, 17'd1};
            12'd6:   q_imem = {OP_SW,   5'd1,  5'd0, 17'd16};
            12'd7:   q_imem = {OP_LW,   5'd8,  5'd0, 17'd16};
            12'd8:   q_imem = {OP_R,    5'd3,  5'd20, 5'd20, 5'd0, 5'd1, 2'd0};
            12'd9:   q_imem = {OP_LW,   5'd9,  5'd0, 17'h00F12};
            12'd10:  q_imem = {OP_LW,   5'd10, 5'd0, 17'h00F1F};
            12'd11:  q_imem = {OP_LW,   5'd11, 5'd0, 17'h00F22};
            12'd12:  q_imem = {OP_LW,   5'd12, 5'd0, 17'h00F30};
            12'd13:  q_imem = {OP_LW,   5'd13, 5'd0, 17'h00FFF};
            12'd14:  q_imem = {OP_ADDI, 5'd4,  5'd0, 17'd77};
            12'd15:  q_imem = {OP_SW,   5'd4,  5'd0, 17'd5};
            12'd16:  q_imem = {OP_SW,   5'd0,  5'd0, 17'h00F05};
            12'd17:  q_imem = {OP_LW,   5'd6,  5'd0, 17'd5};
            12'd18:  q_imem = {OP_ADDI, 5'd4,  5'd0, 17'd128};
            12'd19:  q_imem = {OP_SW,   5'd4,  5'd0, 17'h00F00};
            12'd20:  q_imem = {OP_LW,   5'd5,  5'd0, 17'h00F00};
            12'd21:  q_imem = {OP_LW,   5'd7,  5'd0, 17'h00F20};
            12'd22:  q_imem = {OP_J,    27'd21};
            default: q_imem = 32'd0;
        endcase
    end

    // ---------------- processor decode ----------------
    assign opcode = q_imem[31:27];
    assign rd     = q_imem[26:22];
    assign rs     = q_imem[21:17];
    assign rt     = q_imem[16:12];
    assign aluop  = q_imem[6:2];
    assign imm_sx = {{15{q_imem[16]}}, q_imem[16:0]};

    // Stores read the data register through port B, so rd is steered there.
    assign ctrl_readRegA = rs;
    assign ctrl_readRegB = (opcode == OP_SW) ? rd : rt;
    assign data_readRegA = register_output[ctrl_readRegA];
    assign data_readRegB = register_output[ctrl_readRegB];
    assign address_dmem  = data_readRegA[11:0] + imm_sx[11:0];
    assign d_dmem        = data_readRegB;

    always_comb begin
        region = RG_NONE;
        if (address_dmem < 12'hF00)       region = RG_RAM;
        else if (address_dmem <= 12'hF11) region = RG_LED;
        else if (address_dmem == 12'hF20) region = RG_TOUCH;
        else if (address_dmem == 12'hF21) region = RG_RAND;
    end

    assign store_go  = (state == S_EXEC) && (opcode == OP_SW) && !reset;
    assign wren_dmem = store_go && (region == RG_RAM);
    assign led_we    = store_go && (region == RG_LED);

    // Region is registered so MMIO data lines up with the one-cycle dmem read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_region_q <= RG_NONE;
            led_idx_q   <= 5'd0;
        end else begin
            rd_region_q <= region;
            led_idx_q   <= address_dmem[4:0];
        end
    end

    always_comb begin
        load_data = 32'd0;
        case (rd_region_q)
            RG_RAM:   load_data = q_dmem;
            RG_LED:   load_data = {24'd0, led_commands[led_idx_q*8 +: 8]};
            RG_TOUCH: load_data = {23'd0, touch};
            RG_RAND:  load_data = {24'd0, random_data};
            default:  load_data = 32'd0;
        endcase
    end

    // ---------------- processor control FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_EXEC;
            pc    <= 32'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = rd;
        data_writeReg    = 32'd0;
        case (state)
            S_EXEC: begin
                pc_nxt = pc + 32'd1;
                if (opcode == OP_J) begin
                    pc_nxt = {5'd0, q_imem[26:0]};
                end else if (opcode == OP_LW) begin
                    // Hold the PC so the load's rd is still decoded in S_LOAD.
                    pc_nxt    = pc;
                    state_nxt = S_LOAD;
                end else if (opcode == OP_R) begin
                    ctrl_writeEnable = 1'b1;
                    data_writeReg    = (aluop == 5'd1) ? data_readRegA - data_readRegB
                                                       : data_readRegA + data_readRegB;
                end else if (opcode == OP_ADDI) begin
                    ctrl_writeEnable = 1'b1;
                    data_writeReg    = data_readRegA + imm_sx;
                end
            end
            S_LOAD: begin
                ctrl_writeEnable = 1'b1;
                data_writeReg    = load_data;
                pc_nxt           = pc + 32'd1;
                state_nxt        = S_EXEC;
            end
            default: state_nxt = S_EXEC;
        endcase
    end

    // ---------------- regfile (r0 never written) ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) register_output[i] <= 32'd0;
        end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
            register_output[ctrl_writeReg] <= data_writeReg;
        end
    end

    // ---------------- dmem: contents survive reset ----------------
    always_ff @(posedge clock) begin
        if (wren_dmem) dmem_mem[address_dmem] <= d_dmem;
        q_dmem <= dmem_mem[address_dmem];
    end

    // ---------------- LED commands and PWM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            led_commands <= 144'd0;
            pwm          <= 8'd0;
        end else begin
            pwm <= pwm + 8'd1;
            if (led_we) led_commands[address_dmem[4:0]*8 +: 8] <= d_dmem[7:0];
        end
    end

    always_comb begin
        for (int i = 0; i < 18; i++) led_pins[i] = (pwm < led_commands[i*8 +: 8]);
    end

    // ---------------- capacitive touch sensing ----------------
    // Pads charge while the drive is high; a touched pad stays low longer.
    assign capacitive_sensors_out = ~phase[7];

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= 8'd0;
            touch <= 9'd0;
            for (int i = 0; i < 9; i++) delay_cnt[i] <= 7'd0;
        end else begin
            phase <= phase + 8'd1;
            for (int i = 0; i < 9; i++) begin
                if (phase == 8'd0) begin
                    delay_cnt[i] <= 7'd0;
                end else if (capacitive_sensors_out && !capacitive_sensors_in[i]
                             && delay_cnt[i] != 7'd127) begin
                    delay_cnt[i] <= delay_cnt[i] + 7'd1;
                end
                if (phase == 8'd128) touch[i] <= ({25'd0, delay_cnt[i]} > SENSE_THRESH);
            end
        end
    end

    // ---------------- LFSR random source ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) cell_data[i] <= seeds[i*8 +: 8];
        end else begin
            for (int i = 0; i < 8; i++)
                cell_data[i] <= (cell_data[i] >> 1) ^ (cell_data[i][0] ? 8'hB8 : 8'h00);
        end
    end

    always_comb begin
        random_data = 8'd0;
        for (int i = 0; i < 8; i++) random_data = random_data ^ cell_data[i];
    end

endmodule

// File: tb/tb_skeleton_top.sv
module tb_skeleton_top;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] address_imem, address_dmem;
    logic [31:0] q_imem, d_dmem, q_dmem;
    logic        wren_dmem, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
    logic [31:0] data_writeReg, data_readRegA, data_readRegB;
    logic [17:0] led_pins;
    logic [8:0]  sens = 9'h1F7;
    logic        cap_out;

    skeleton_top dut (
        .clock(clock), .reset(reset),
        .address_imem(address_imem), .q_imem(q_imem),
        .address_dmem(address_dmem), .d_dmem(d_dmem), .wren_dmem(wren_dmem), .q_dmem(q_dmem),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
        .data_writeReg(data_writeReg), .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
        .led_pins(led_pins),
        .capacitive_sensors_in(sens), .capacitive_sensors_out(cap_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int bad_wren = 0;
    int zero_cells = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for cap_out to reach lvl from the opposite level.
    task automatic wait_cap(input logic lvl, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = cap_out;
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            if (cap_out == lvl && prev != lvl) begin
                ok = 1'b1;
                break;
            end
            prev = cap_out;
        end
    endtask

    // Continuous watch: no RAM write strobe outside RAM, LFSR cells never zero.
    always @(negedge clock) begin
        if (!reset) begin
            if (wren_dmem && address_dmem >= 12'hF00) bad_wren++;
            for (int i = 0; i < 8; i++) if (dut.cell_data[i] == 8'd0) zero_cells++;
        end
    end

    typedef struct { int idx; logic [31:0] exp; } reg_vec_t;
    typedef struct { logic [8:0] pads; logic [8:0] exp_touch; } touch_vec_t;
    typedef struct { int low_cycles; logic [8:0] exp_touch; } thr_vec_t;

    reg_vec_t   regs [15];
    touch_vec_t tvec [4];
    thr_vec_t   thr  [2];

    initial begin
        bit ok;
        int hi0, hi_other, nonzero_regs;

        regs[0]  = '{8,  32'd1};
        regs[1]  = '{9,  32'd0};
        regs[2]  = '{10, 32'd0};
        regs[3]  = '{11, 32'd0};
        regs[4]  = '{12, 32'd0};
        regs[5]  = '{13, 32'd0};
        regs[6]  = '{3,  32'd0};
        regs[7]  = '{20, 32'd12345};
        regs[8]  = '{21, 32'd1900};
        regs[9]  = '{27, 32'd99};
        regs[10] = '{5,  32'd128};
        regs[11] = '{6,  32'd77};
        regs[12] = '{7,  32'h008};
        regs[13] = '{0,  32'd0};
        regs[14] = '{2,  32'd12345};

        tvec[0] = '{9'h1FF, 9'h000};
        tvec[1] = '{9'h000, 9'h1FF};
        tvec[2] = '{9'h0FE, 9'h101};
        tvec[3] = '{9'h1F7, 9'h008};

        thr[0] = '{15, 9'h000};
        thr[1] = '{30, 9'h001};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_led_pins", led_pins, 0);
        check("rst_cap_out", cap_out, 1);
        check("rst_random", dut.random_data, 8'h80);
        check("rst_pc", address_imem, 0);
        check("rst_wren", wren_dmem, 0);

        // First cycle after reset: seed value, then the LFSR step
        reset = 1'b0;
        check("post_rst_random", dut.random_data, 8'h80);
        check("post_rst_cap_out", cap_out, 1);
        @(negedge clock);
        check("random_step1", dut.random_data, 8'h40);

        // Reference program
        repeat (399) @(negedge clock);
        for (int i = 0; i < 15; i++)
            check($sformatf("reg_r%0d", regs[i].idx), dut.register_output[regs[i].idx], regs[i].exp);
        check("ram5_kept", dut.dmem_mem[5], 32'd77);
        check("ram16", dut.dmem_mem[16], 32'd1);
        check("led_field0", {24'd0, dut.led_commands[7:0]}, 32'd128);

        // PWM duty over one full period
        hi0 = 0;
        hi_other = 0;
        for (int n = 0; n < 256; n++) begin
            @(negedge clock);
            if (led_pins[0]) hi0++;
            if (led_pins[17:1] != 17'd0) hi_other++;
        end
        check("led0_duty", hi0, 128);
        check("led_others_off", hi_other, 0);

        // Touch patterns through the program's polling load
        for (int t = 0; t < 4; t++) begin
            sens = tvec[t].pads;
            repeat (600) @(negedge clock);
            check($sformatf("touch_load_%0d", t), dut.register_output[7], {23'd0, tvec[t].exp_touch});
        end

        // Threshold margins on pad 0, phase-aligned to the charge drive
        sens = 9'h1FF;
        for (int t = 0; t < 2; t++) begin
            wait_cap(1'b1, ok);
            if (!ok) check("cap_rise_timeout", 0, 1);
            sens[0] = 1'b0;
            repeat (thr[t].low_cycles) @(negedge clock);
            sens[0] = 1'b1;
            wait_cap(1'b0, ok);
            if (!ok) check("cap_fall_timeout", 0, 1);
            repeat (2) @(negedge clock);
            check($sformatf("thresh_%0d", thr[t].low_cycles), dut.touch, thr[t].exp_touch);
        end

        check("no_mmio_wren", bad_wren, 0);
        check("no_zero_cell", zero_cells, 0);

        // Reset mid-program
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        nonzero_regs = 0;
        for (int i = 0; i < 32; i++) if (dut.register_output[i] != 32'd0) nonzero_regs++;
        check("midrst_regs", nonzero_regs, 0);
        check("midrst_leds", dut.led_commands != 144'd0, 0);
        check("midrst_pc", address_imem, 0);
        check("midrst_dmem_kept", dut.dmem_mem[0], 32'd12345);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skeleton_top.md
SKELETON_TOP -- requirements
Module: skeleton_top

Parameters
REQ-001 SHALL have parameter SENSE_THRESH, default 20: charge-delay cycle count above which a pad is reported touched.
REQ-002 SHALL have parameter RNG_SEED, default 64'h1F2E3D4C5B6A7988: eight 8-bit LFSR seeds, byte i seeds cell i; every byte nonzero.

Interface
REQ-003 SHALL provide: clock  in  1  single system clock; every register updates on its rising edge.
REQ-004 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL provide: address_imem  out  12  instruction-memory word address (processor PC[11:0]).
REQ-006 SHALL provide: q_imem  out  32  instruction word returned by imem.
REQ-007 SHALL provide: address_dmem, d_dmem, wren_dmem, q_dmem  out  12/32/1/32  data-RAM address, write data, write enable and read data.
REQ-008 SHALL provide: ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB  out  1/5/5/5  regfile controls.
REQ-009 SHALL provide: data_writeReg, data_readRegA, data_readRegB  out  32 each  regfile data.
REQ-010 SHALL provide: led_pins  out  18  PWM LED drive, two LEDs per mole.
REQ-011 SHALL provide: capacitive_sensors_in  in  9  touch-pad sense inputs.
REQ-012 SHALL provide: capacitive_sensors_out  out  1  common pad charge drive.

Function
REQ-013 SHALL instantiate the codebase processor, imem (4096x32 ROM), dmem (4096x32 RAM) and regfile (32x32, r0 = 0), with the regfile array named register_output.
REQ-014 SHALL route the processor's imem, dmem and regfile buses to those blocks and expose them unchanged on the outputs above.
REQ-015 SHALL decode processor data addresses: 0x000-0xEFF = RAM, 0xF00-0xF11 = LED command words 0-17, 0xF20 = touch status, 0xF21 = random value; all other addresses read 0, writes ignored.
REQ-016 SHALL assert wren_dmem only for processor stores into 0x000-0xEFF.
REQ-017 SHALL register the decoded region one cycle so MMIO read data aligns with the dmem one-cycle synchronous read latency.
REQ-018 SHALL hold led_commands[143:0] as 18 8-bit fields; a store to 0xF00+i writes d[7:0] into field i; a load returns it zero-extended.
REQ-019 SHALL run an 8-bit free-running pwm counter, wrapping 255 -> 0; led_pins[i] = 1 iff pwm < field i. Field 0 = always off; field 255 = on 255 of 256 cycles.
REQ-020 SHALL drive capacitive_sensors_out from a free-running 8-bit phase counter: high for phases 0-127, low for phases 128-255.
REQ-021 SHALL keep one 7-bit saturating delay counter per pad: cleared at phase 0; increments each cycle while sensors_out is high and the pad input is low; saturates at 127.
REQ-022 SHALL, at phase 128, latch touch[i] = (delay[i] > SENSE_THRESH); touch holds until the next phase 128.
REQ-023 SHALL return {23'b0, touch[8:0]} for loads from 0xF20; stores there are ignored.
REQ-024 SHALL advance eight 8-bit Galois LFSRs (cell_data[0..7]) every cycle: shift right; if the outgoing bit is 1, XOR 0xB8.
REQ-025 SHALL output random_data[7:0] = XOR of all eight cells; loads from 0xF21 return it zero-extended.
REQ-026 SHALL expose seeds[63:0] = RNG_SEED as an internal wire.
REQ-027 SHALL, when the same cycle carries a processor store and a pwm/phase wrap, apply the store; the new LED value takes effect from the next cycle.

Reset
REQ-028 SHALL, while reset is high at a clock edge: clear processor PC and pipeline, all regfile registers, led_commands, pwm and phase counters, delay counters and touch; load each cell i with RNG_SEED byte i.
REQ-029 SHALL, during and on the cycle after reset: drive led_pins = 0, capacitive_sensors_out = 1 (phase 0), and random_data = 8'h80.
REQ-030 SHALL leave dmem contents unchanged by reset.

Verification
REQ-031 SHALL pass: the reference imem program run 400 cycles after reset -> r8=1; r9-r13=0; r3=0; r20=12345; r21=1900; r27=99.
REQ-032 SHALL pass: store 128 to 0xF00 -> led_pins[0] high for exactly 128 of every 256 cycles; led_pins[17:1] stay 0; a load from 0xF00 returns 128.
REQ-033 SHALL pass: pad 3 held low, others high -> a load from 0xF20 after phase 128 returns 0x008.
REQ-034 SHALL pass: deassert reset -> random_data = 0x80, then changes on the next cycle; no cell ever becomes 0.
REQ-035 SHALL pass: store to 0xF05 -> wren_dmem stays 0 and the RAM word at 0x005 is unchanged.
REQ-036 SHALL pass: reset asserted mid-program -> all registers and LED fields return to 0 on the next edge.
